// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tile_pkg
//  Description : Shared tile geometry defaults, mode type and collector FSM
//                state encoding. Used by the tile output collector, the
//                reduction accumulator and their benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package tile_pkg;

    localparam int TILE_SIZE_DEF = 4;
    localparam int ACC_WIDTH_DEF = 32;

    typedef logic [2:0] mode_t;

    typedef enum logic [1:0] {
        COL_IDLE  = 2'd0,
        COL_CLEAR = 2'd1,
        COL_SEND  = 2'd2
    } col_state_e;

endpackage
`default_nettype wire

// File: rtl/tile_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tile_buffer
//  Description : One TILE_SIZE x TILE_SIZE register bank. Rows are written
//                one at a time by index; the first/mode side registers are
//                captured together with row 0. The whole tile is readable.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_n        clock, async active-low reset
//                wr_en, wr_row     row write strobe and row index
//                wr_data           row contents
//                wr_first, wr_mode side info, captured when wr_row == 0
//                mat, first, mode  full tile and side info read port
// ============================================================================
module tile_buffer
    import tile_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int ROW_W     = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       wr_en,
    input  logic [ROW_W-1:0]                           wr_row,
    input  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0]        wr_data,
    input  logic                                       wr_first,
    input  mode_t                                      wr_mode,
    output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] mat,
    output logic                                       first,
    output mode_t                                      mode
);

    logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] r_mat;
    logic                                               r_first;
    mode_t                                              r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat   <= '0;
            r_first <= 1'b0;
            r_mode  <= '0;
        end else if (wr_en) begin
            r_mat[wr_row] <= wr_data;
            if (wr_row == '0) begin
                r_first <= wr_first;
                r_mode  <= wr_mode;
            end
        end
    end

    assign mat   = r_mat;
    assign first = r_first;
    assign mode  = r_mode;

endmodule
`default_nettype wire

// File: rtl/tile_output_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tile_output_collector
//  Description : Gathers row-serial systolic array results into tiles in a
//                pair of ping-pong buffers and issues each tile downstream as
//                an optional one-cycle clear followed by a held valid cycle.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_n               clock, async active-low reset
//                flush                    synchronous drop of all tiles
//                row_valid/row_ready      row handshake, row_data payload
//                row_first, row_mode      tile side info, sampled with row 0
//                clear_out, valid_out     downstream strobes (Moore)
//                out_ready                downstream acceptance
//                mat_out, mode_out        tile payload while valid_out
//                err_overflow             sticky dropped-row flag
// ============================================================================
module tile_output_collector
    import tile_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       flush,
    input  logic                                       row_valid,
    output logic                                       row_ready,
    input  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0]        row_data,
    input  logic                                       row_first,
    input  mode_t                                      row_mode,
    output logic                                       clear_out,
    output logic                                       valid_out,
    input  logic                                       out_ready,
    output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] mat_out,
    output mode_t                                      mode_out,
    output logic                                       err_overflow
);

    localparam int              ROW_W      = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(TILE_SIZE - 1);

    col_state_e       r_state;
    col_state_e       w_state_nxt;
    logic [1:0]       r_full;
    logic [1:0]       w_full_nxt;
    logic [1:0]       w_first_nxt;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [ROW_W-1:0] r_row_idx;
    logic             r_err;
    logic             w_row_ready;
    logic             w_accept;
    logic             w_fire;
    logic             w_last;

    logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] w_buf_mat [2];
    logic [1:0]                                         w_buf_first;
    mode_t                                              w_buf_mode [2];

    for (genvar g = 0; g < 2; g++) begin : g_buf
        tile_buffer #(
            .TILE_SIZE (TILE_SIZE),
            .ACC_WIDTH (ACC_WIDTH),
            .ROW_W     (ROW_W)
        ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (w_accept && (r_wr_sel == 1'(g))),
            .wr_row   (r_row_idx),
            .wr_data  (row_data),
            .wr_first (row_first),
            .wr_mode  (row_mode),
            .mat      (w_buf_mat[g]),
            .first    (w_buf_first[g]),
            .mode     (w_buf_mode[g])
        );
    end

    // Look-ahead of the full/first flags as they will be after this edge, so
    // the read FSM can leave IDLE on the very edge the last row lands.
    always_comb begin
        w_row_ready = !r_full[r_wr_sel];
        w_accept    = row_valid && w_row_ready && !flush;
        w_last      = (r_row_idx == c_LAST_ROW);
        w_fire      = (r_state == COL_SEND) && out_ready;
        for (int b = 0; b < 2; b++) begin
            w_full_nxt[b]  = r_full[b];
            w_first_nxt[b] = w_buf_first[b];
            if (w_fire && (r_rd_sel == 1'(b)))
                w_full_nxt[b] = 1'b0;
            if (w_accept && (r_wr_sel == 1'(b)) && w_last)
                w_full_nxt[b] = 1'b1;
            if (w_accept && (r_wr_sel == 1'(b)) && (r_row_idx == '0))
                w_first_nxt[b] = row_first;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            COL_IDLE: begin
                if (w_full_nxt[r_rd_sel])
                    w_state_nxt = w_first_nxt[r_rd_sel] ? COL_CLEAR : COL_SEND;
            end
            COL_CLEAR: w_state_nxt = COL_SEND;
            COL_SEND: begin
                if (out_ready) begin
                    if (w_full_nxt[~r_rd_sel])
                        w_state_nxt = w_first_nxt[~r_rd_sel] ? COL_CLEAR : COL_SEND;
                    else
                        w_state_nxt = COL_IDLE;
                end
            end
            default: w_state_nxt = COL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= COL_IDLE;
            r_full    <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_row_idx <= '0;
            r_err     <= 1'b0;
        end else if (flush) begin
            // Overflow history survives a flush; only reset clears it.
            r_state   <= COL_IDLE;
            r_full    <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_row_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            if (w_accept) begin
                if (w_last) begin
                    r_row_idx <= '0;
                    r_wr_sel  <= ~r_wr_sel;
                end else begin
                    r_row_idx <= r_row_idx + ROW_W'(1);
                end
            end
            if (w_fire)
                r_rd_sel <= ~r_rd_sel;
            if (row_valid && !w_row_ready)
                r_err <= 1'b1;
        end
    end

    assign row_ready    = w_row_ready;
    assign clear_out    = (r_state == COL_CLEAR);
    assign valid_out    = (r_state == COL_SEND);
    assign mat_out      = (r_state == COL_SEND) ? w_buf_mat[r_rd_sel] : '0;
    assign mode_out     = (r_state == COL_SEND) ? w_buf_mode[r_rd_sel] : '0;
    assign err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tile_output_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_output_collector
//  Description : Directed self-checking bench for tile_output_collector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_output_collector;
    import tile_pkg::*;

    typedef logic [3:0][3:0][31:0] tile_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        row_valid;
    logic        row_ready;
    logic [3:0][31:0] row_data;
    logic        row_first;
    mode_t       row_mode;
    logic        clear_out;
    logic        valid_out;
    logic        out_ready;
    tile_t       mat_out;
    mode_t       mode_out;
    logic        err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Downstream monitor state
    logic  mon_en = 1'b0;
    int    n_clr  = 0;
    int    n_both = 0;
    tile_t mon_q [$];
    mode_t mon_m [$];

    tile_output_collector #(
        .TILE_SIZE (4),
        .ACC_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_data     (row_data),
        .row_first    (row_first),
        .row_mode     (row_mode),
        .clear_out    (clear_out),
        .valid_out    (valid_out),
        .out_ready    (out_ready),
        .mat_out      (mat_out),
        .mode_out     (mode_out),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clear_out && valid_out)
            n_both++;
        if (mon_en) begin
            if (clear_out)
                n_clr++;
            if (valid_out && out_ready) begin
                mon_q.push_back(mat_out);
                mon_m.push_back(mode_out);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tile_t exp_tile(input int base);
        tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[i][j] = 32'(base + i * 10 + j);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(input int base, input int i, input logic first, input mode_t mode);
        row_valid = 1'b1;
        row_first = first;
        row_mode  = mode;
        for (int j = 0; j < 4; j++)
            row_data[j] = 32'(base + i * 10 + j);
    endtask

    // Four back-to-back rows; returns one step after the last accepting edge.
    task automatic send_tile(input int base, input logic first, input mode_t mode);
        for (int i = 0; i < 4; i++) begin
            drive_row(base, i, first, mode);
            tick();
        end
        row_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        row_valid = 1'b0;
        row_data  = '0;
        row_first = 1'b0;
        row_mode  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_clear", clear_out, 0);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_err",   err_overflow, 0);
        check_eq("rst_mat",   mat_out, 0);
        rst_n = 1'b1;

        // 1: single tile with clear
        send_tile(0, 1'b1, 3'd0);
        check_eq("t1_clear",    clear_out, 1);
        check_eq("t1_noval",    valid_out, 0);
        tick();
        check_eq("t1_valid",    valid_out, 1);
        check_eq("t1_clr_low",  clear_out, 0);
        check_eq("t1_mat",      mat_out, exp_tile(0));
        check_eq("t1_mode",     mode_out, 0);
        tick();
        check_eq("t1_done",     valid_out, 0);

        // 2: four tiles, clear on the first only
        mon_en = 1'b1;
        for (int t = 0; t < 4; t++)
            send_tile(t * 100, (t == 0), mode_t'(t + 1));
        repeat (4) tick();
        mon_en = 1'b0;
        check_eq("t2_nclear", n_clr, 1);
        check_eq("t2_nvalid", mon_q.size(), 4);
        for (int t = 0; t < 4 && t < mon_q.size(); t++) begin
            check_eq($sformatf("t2_mat%0d", t),  mon_q[t], exp_tile(t * 100));
            check_eq($sformatf("t2_mode%0d", t), mon_m[t], t + 1);
        end

        // 3/4: stall downstream, fill both buffers, overflow once
        out_ready = 1'b0;
        send_tile(200, 1'b0, 3'd3);
        send_tile(300, 1'b0, 3'd4);
        check_eq("t3_rdy_low",   row_ready, 0);
        check_eq("t3_valid",     valid_out, 1);
        check_eq("t3_mat0",      mat_out, exp_tile(200));
        drive_row(900, 0, 1'b0, 3'd7);
        tick();
        row_valid = 1'b0;
        check_eq("t4_err",       err_overflow, 1);
        repeat (2) tick();
        check_eq("t4_err_stick", err_overflow, 1);
        check_eq("t3_mat_hold",  mat_out, exp_tile(200));
        check_eq("t3_mode_hold", mode_out, 3);
        out_ready = 1'b1;
        tick();
        check_eq("t3_rdy_back",  row_ready, 1);
        check_eq("t3_valid1",    valid_out, 1);
        check_eq("t3_mat1",      mat_out, exp_tile(300));
        check_eq("t3_mode1",     mode_out, 4);
        tick();
        check_eq("t3_idle",      valid_out, 0);

        // 5: flush a partial tile
        drive_row(400, 0, 1'b1, 3'd6);
        tick();
        drive_row(400, 1, 1'b1, 3'd6);
        tick();
        row_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send_tile(500, 1'b0, 3'd5);
        check_eq("t5_noclear", clear_out, 0);
        check_eq("t5_valid",   valid_out, 1);
        check_eq("t5_mat",     mat_out, exp_tile(500));
        check_eq("t5_mode",    mode_out, 5);
        check_eq("t5_err",     err_overflow, 1);
        tick();
        check_eq("t5_done",    valid_out, 0);
        repeat (3) tick();
        check_eq("t5_nores",   valid_out | clear_out, 0);

        // 6: reset in the middle of a held SEND
        out_ready = 1'b0;
        send_tile(600, 1'b0, 3'd1);
        check_eq("t6_valid", valid_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", valid_out, 0);
        check_eq("t6_rst_clear", clear_out, 0);
        check_eq("t6_rst_mat",   mat_out, 0);
        check_eq("t6_rst_err",   err_overflow, 0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send_tile(700, 1'b1, 3'd2);
        check_eq("t6_clear",  clear_out, 1);
        tick();
        check_eq("t6_valid2", valid_out, 1);
        check_eq("t6_mat",    mat_out, exp_tile(700));
        check_eq("t6_mode",   mode_out, 2);
        tick();
        check_eq("t6_done",   valid_out, 0);

        check_eq("excl_clear_valid", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
